prefetch_dram_fetcher: RTL and testbench
========================================

// Module: prefetch_dram_fetcher
// PURPOSE
// Consumer end of the prefetch initiate FIFO: pops one expanded line address per pop, issues a DRAM read
// request per address (valid/ready), tracks in-flight reads, and writes each in-order DRAM response into the
// next prefetch cache slot. Sits between the prefetch initiate FIFO and the DRAM read port / cache write port.
// PARAMETERS
// LINE            18   width of a DRAM line address (matches FIFO dat_r)
// DATA_W          256  width of one DRAM line / cache line
// MAX_OUTSTANDING 8    max DRAM reads in flight (power of 2, >=2)
// SLOT_W          4    cache slot index width; slots wrap modulo 2**SLOT_W
// PORTS
// clk             in   1        clock
// reset           in   1        synchronous, active-high reset
// fifo_emptyn     in   1        FIFO has an address available
// fifo_dat_r      in   LINE     FIFO read data; valid the cycle after fifo_re && fifo_emptyn
// fifo_re         out  1        pop request to FIFO
// mem_req_valid   out  1        DRAM read request valid
// mem_req_ready   in   1        DRAM accepts request this cycle
// mem_req_addr    out  LINE     DRAM read line address
// mem_resp_valid  in   1        DRAM read data valid (in request order, no backpressure)
// mem_resp_data   in   DATA_W   DRAM read data
// cache_we        out  1        cache write strobe
// cache_addr      out  SLOT_W   cache slot written
// cache_dat       out  DATA_W   cache write data
// busy            out  1        any pop, request, read or write pending
// err             out  1        sticky: response received with zero outstanding
// BEHAVIOUR
// - Reset (sync, active-high; wins over all other events): state=IDLE, outstanding=0, slot_ptr=0; all outputs 0
//   (fifo_re, mem_req_valid, mem_req_addr, cache_we, cache_addr, cache_dat, busy, err). In-flight DRAM data
//   arriving after reset is counted as unexpected (sets err).
// - credit = (outstanding + (state==ISSUE)) < MAX_OUTSTANDING.
// - States: IDLE, WAIT, ISSUE.
//   IDLE : fifo_re = fifo_emptyn && credit; if asserted -> WAIT.
//   WAIT : register mem_req_addr <= fifo_dat_r -> ISSUE. fifo_re=0.
//   ISSUE: mem_req_valid=1, mem_req_addr held stable until accepted. On mem_req_ready: outstanding++,
//          and if fifo_emptyn && (outstanding+1 < MAX_OUTSTANDING, post-increment check) assert fifo_re and go
//          to WAIT, else go to IDLE. No ready: stay in ISSUE.
// - fifo_re is combinational from state/fifo_emptyn/outstanding; never asserted in WAIT, never while
//   fifo_emptyn=0. Peak issue rate: one request per 2 cycles.
// - Responses: on mem_resp_valid, next cycle cache_we=1, cache_addr=slot_ptr, cache_dat=mem_resp_data (1-cycle
//   latency); slot_ptr increments mod 2**SLOT_W; outstanding--. cache_we is a 1-cycle pulse per response.
// - Request accepted and response in same cycle: outstanding unchanged.
// - mem_resp_valid with outstanding==0: err<=1 (sticky until reset), no cache write, counter stays 0.
// - outstanding width clog2(MAX_OUTSTANDING)+1; never exceeds MAX_OUTSTANDING (assert).
// - busy = state!=IDLE || outstanding!=0 || cache_we.
// TESTING
// 1 Reset, FIFO empty 10 cycles -> fifo_re=0, mem_req_valid=0, busy=0, all outputs 0.
// 2 FIFO yields 0x100,0x104,0x108, mem_req_ready=1, DRAM replies 5 cycles after each accept -> requests in order
//   every 2 cycles, cache writes to slots 0,1,2 with matching data, busy falls after last cache_we.
// 3 mem_req_ready=0 for 7 cycles in ISSUE -> mem_req_valid=1 and mem_req_addr stable, fifo_re=0 throughout.
// 4 MAX_OUTSTANDING=8, 12 addresses, no responses -> exactly 8 accepted, fifo_re held 0; one response ->
//   one more pop/issue.
// 5 Accept and response in same cycle at outstanding=3 -> outstanding stays 3; 17 responses total -> slot_ptr
//   wraps 15->0 on 17th write.
// 6 mem_resp_valid with outstanding=0 -> err=1, no cache_we; reset asserted in ISSUE with outstanding=4 ->
//   next cycle state IDLE, outstanding=0, err=0.

Source files
------------

// File: rtl/prefetch_dram_fetcher_if.sv
// Bus bundle for the prefetch DRAM fetcher: FIFO pop side, DRAM read
// request/response, and prefetch cache write port.
interface prefetch_dram_fetcher_if #(
  parameter int LINE   = 18,
  parameter int DATA_W = 256,
  parameter int SLOT_W = 4
);
  logic              fifo_emptyn;
  logic [LINE-1:0]   fifo_dat_r;
  logic              fifo_re;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [LINE-1:0]   mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              cache_we;
  logic [SLOT_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_dat;

  // The fetcher itself
  modport master (
    input  fifo_emptyn, fifo_dat_r, mem_req_ready, mem_resp_valid, mem_resp_data,
    output fifo_re, mem_req_valid, mem_req_addr, cache_we, cache_addr, cache_dat
  );

  // FIFO, DRAM and cache as seen from the other side
  modport slave (
    output fifo_emptyn, fifo_dat_r, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  fifo_re, mem_req_valid, mem_req_addr, cache_we, cache_addr, cache_dat
  );
endinterface

// File: rtl/prefetch_dram_fetcher.sv
// Prefetch DRAM fetcher: pops line addresses from the prefetch initiate FIFO,
// issues one DRAM read per address while credits remain, and writes the
// in-order DRAM responses into consecutive prefetch cache slots.
module prefetch_dram_fetcher #(
  parameter int LINE            = 18,
  parameter int DATA_W          = 256,
  parameter int MAX_OUTSTANDING = 8,
  parameter int SLOT_W          = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  prefetch_dram_fetcher_if.master bus,
  output logic                    busy,
  output logic                    err
);

  localparam int OCNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OCNT_W-1:0] MAX_CNT = OCNT_W'(MAX_OUTSTANDING);
  localparam logic [OCNT_W-1:0] ONE_CNT = OCNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t              state_reg, state_next;
  logic [OCNT_W-1:0]   outstanding_reg, outstanding_next;
  logic [SLOT_W-1:0]   slot_ptr_reg;
  logic [LINE-1:0]     req_addr_reg;
  logic                cache_we_reg;
  logic [SLOT_W-1:0]   cache_addr_reg;
  logic [DATA_W-1:0]   cache_dat_reg;
  logic                err_reg;
  logic                pop;
  logic                credit;
  logic                accept;
  logic                resp_ok;

  // The request in ISSUE already holds a credit even though it is not yet counted.
  assign credit  = (outstanding_reg + {{(OCNT_W-1){1'b0}}, (state_reg == ISSUE)}) < MAX_CNT;
  assign accept  = (state_reg == ISSUE) && bus.mem_req_ready;
  // A response with nothing in flight is a protocol error and is dropped.
  assign resp_ok = bus.mem_resp_valid && (outstanding_reg != '0);

  // Next-state and pop decision; popping from ISSUE overlaps the next fetch with acceptance.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.fifo_emptyn && credit) begin
          pop        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: state_next = ISSUE;
      ISSUE: begin
        if (bus.mem_req_ready) begin
          if (bus.fifo_emptyn && ((outstanding_reg + ONE_CNT) < MAX_CNT)) begin
            pop        = 1'b1;
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // In-flight count: an accept and a response in the same cycle cancel out.
  always_comb begin
    outstanding_next = outstanding_reg;
    case ({accept, resp_ok})
      2'b10:   outstanding_next = outstanding_reg + ONE_CNT;
      2'b01:   outstanding_next = outstanding_reg - ONE_CNT;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  // Control state: FSM, in-flight counter, slot pointer and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      outstanding_reg <= '0;
      slot_ptr_reg    <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      if (resp_ok) begin
        slot_ptr_reg <= slot_ptr_reg + 1'b1;
      end
      if (bus.mem_resp_valid && (outstanding_reg == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Datapath: capture popped address in WAIT, register each response into the cache port.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_reg   <= '0;
      cache_we_reg   <= 1'b0;
      cache_addr_reg <= '0;
      cache_dat_reg  <= '0;
    end else begin
      if (state_reg == WAIT) begin
        req_addr_reg <= bus.fifo_dat_r;
      end
      cache_we_reg <= resp_ok;
      if (resp_ok) begin
        cache_addr_reg <= slot_ptr_reg;
        cache_dat_reg  <= bus.mem_resp_data;
      end
    end
  end

  // The counter must never run past the credit limit.
  assert property (@(posedge clk) disable iff (reset) outstanding_reg <= MAX_CNT);

  assign bus.fifo_re       = pop && !reset;
  assign bus.mem_req_valid = (state_reg == ISSUE);
  assign bus.mem_req_addr  = req_addr_reg;
  assign bus.cache_we      = cache_we_reg;
  assign bus.cache_addr    = cache_addr_reg;
  assign bus.cache_dat     = cache_dat_reg;
  assign busy              = (state_reg != IDLE) || (outstanding_reg != '0) || cache_we_reg;
  assign err               = err_reg;

endmodule

// File: tb/tb_prefetch_dram_fetcher.sv
// Self-checking bench for prefetch_dram_fetcher: FIFO and DRAM models,
// request/cache-write scoreboards, a vector table and corner-case sequences.
module tb_prefetch_dram_fetcher;
  localparam int LINE = 18, DATA_W = 256, MAXO = 8, SLOT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy, err;

  prefetch_dram_fetcher_if #(.LINE(LINE), .DATA_W(DATA_W), .SLOT_W(SLOT_W)) bus ();

  prefetch_dram_fetcher #(.LINE(LINE), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .SLOT_W(SLOT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [LINE-1:0] addr; int due; } pend_t;
  typedef struct { logic [SLOT_W-1:0] slot; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { logic [LINE-1:0] addr; logic [SLOT_W-1:0] exp_slot; logic [DATA_W-1:0] exp_data; } vec_t;

  int checks = 0, errors = 0;
  logic [LINE-1:0] fifo_q[$];
  logic [LINE-1:0] req_exp[$];
  pend_t pend_q[$];
  wr_t   wr_exp[$];
  wr_t   wr_log[$];
  int    acc_cyc[$];
  int    cyc = 0, acc_count = 0, wr_count = 0, out_model = 0;
  int    resp_delay = 5, resp_budget = -1;
  bit    inject = 1'b0;
  bit    chk_out_flag = 1'b0;
  logic [SLOT_W-1:0] slot_model = '0;

  function automatic logic [DATA_W-1:0] data_of(input logic [LINE-1:0] a);
    return {8{{14'h1A5C, a}}};
  endfunction

  function automatic void chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // FIFO + DRAM model and scoreboards: sample at negedge, update inputs just after posedge.
  initial begin : model
    bit rst_s, fre_s, acc_s, resp_s, coincide;
    logic [LINE-1:0]   acc_addr;
    logic [DATA_W-1:0] resp_data_s;
    pend_t p;
    wr_t   w;
    bus.fifo_emptyn    = 1'b0;
    bus.fifo_dat_r     = '0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      rst_s       = reset;
      fre_s       = bus.fifo_re;
      acc_s       = bus.mem_req_valid && bus.mem_req_ready;
      acc_addr    = bus.mem_req_addr;
      resp_s      = bus.mem_resp_valid;
      resp_data_s = bus.mem_resp_data;
      if (!rst_s) begin
        if (bus.fifo_re) chk("fifo_re_nonempty", bus.fifo_emptyn, 1);
        if (acc_s) begin
          $display("accept addr=%0h cyc=%0d", acc_addr, cyc);
          if (req_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got addr %0h, expected no request", acc_addr);
          end else begin
            chk("req_addr", acc_addr, req_exp.pop_front());
          end
        end
        if (bus.cache_we) begin
          $display("write slot=%0d data=%h", bus.cache_addr, bus.cache_dat);
          w.slot = bus.cache_addr; w.data = bus.cache_dat;
          wr_log.push_back(w);
          wr_count++;
          if (wr_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL cache_we_unexpected: got write slot %0d, expected none", bus.cache_addr);
          end else begin
            w = wr_exp.pop_front();
            chk("cache_addr", bus.cache_addr, w.slot);
            chk("cache_dat", bus.cache_dat, w.data);
          end
        end
        if (chk_out_flag) chk("outstanding_same_cycle", dut.outstanding_reg, out_model);
      end
      chk_out_flag = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_s) begin
        out_model  = 0;
        slot_model = '0;
      end else begin
        if (fre_s && fifo_q.size() != 0) bus.fifo_dat_r = fifo_q.pop_front();
        coincide = acc_s && resp_s && (out_model > 0);
        if (resp_s && out_model > 0) begin
          w.slot = slot_model; w.data = resp_data_s;
          wr_exp.push_back(w);
          slot_model++;
          out_model--;
        end
        if (acc_s) begin
          out_model++;
          acc_count++;
          acc_cyc.push_back(cyc);
          p.addr = acc_addr; p.due = cyc + resp_delay;
          pend_q.push_back(p);
        end
        chk_out_flag = coincide;
      end
      bus.fifo_emptyn    = (fifo_q.size() != 0);
      bus.mem_resp_valid = 1'b0;
      if (inject) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {DATA_W{1'b1}};
        inject = 1'b0;
      end else if (!rst_s && pend_q.size() != 0 && pend_q[0].due <= cyc && resp_budget != 0) begin
        p = pend_q.pop_front();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data_of(p.addr);
        if (resp_budget > 0) resp_budget--;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_addr(input logic [LINE-1:0] a);
    fifo_q.push_back(a);
    req_exp.push_back(a);
  endtask

  task automatic clear_model();
    fifo_q.delete(); req_exp.delete(); pend_q.delete(); wr_exp.delete();
    resp_budget = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    bus.mem_req_ready = 1'b0;
    clear_model();
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int k = 0;
    while (wr_count < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (wr_count < n) begin
      checks++; errors++;
      $display("FAIL %s: got %0d writes, expected %0d", name, wr_count, n);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!bus.mem_req_valid && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, bus.mem_req_valid, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[3];
    int base_w, base_a, k;
    vecs[0] = '{18'h100, 4'd0, data_of(18'h100)};
    vecs[1] = '{18'h104, 4'd1, data_of(18'h104)};
    vecs[2] = '{18'h108, 4'd2, data_of(18'h108)};

    // 1: reset, FIFO empty for 10 cycles
    reset = 1'b1;
    bus.mem_req_ready = 1'b0;
    cycles(3);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_fifo_re", bus.fifo_re, 0);
      chk("idle_req_valid", bus.mem_req_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cache_we", bus.cache_we, 0);
      chk("idle_err", err, 0);
    end
    chk("idle_req_addr", bus.mem_req_addr, 0);
    chk("idle_cache_addr", bus.cache_addr, 0);
    chk("idle_cache_dat", bus.cache_dat, 0);

    // 2: three-address stream from the vector table
    @(posedge clk); #2;
    bus.mem_req_ready = 1'b1;
    resp_delay = 5;
    wr_log.delete(); acc_cyc.delete();
    base_w = wr_count;
    for (int i = 0; i < 3; i++) push_addr(vecs[i].addr);
    wait_writes("stream_writes", base_w + 3, 80);
    chk("busy_at_last_write", busy, 1);
    @(negedge clk); #1;
    chk("busy_after_last_write", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("vec_slot", wr_log[i].slot, vecs[i].exp_slot);
      chk("vec_data", wr_log[i].data, vecs[i].exp_data);
    end
    chk("issue_gap_1", 32'(acc_cyc[1] - acc_cyc[0]), 2);
    chk("issue_gap_2", 32'(acc_cyc[2] - acc_cyc[1]), 2);

    // 3: DRAM stalls the request for 7 cycles
    @(posedge clk); #2;
    bus.mem_req_ready = 1'b0;
    base_w = wr_count;
    push_addr(18'h200);
    push_addr(18'h204);
    wait_valid("stall_reach_issue", 30);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      chk("stall_valid", bus.mem_req_valid, 1);
      chk("stall_addr", bus.mem_req_addr, 18'h200);
      chk("stall_fifo_re", bus.fifo_re, 0);
    end
    @(posedge clk); #2;
    bus.mem_req_ready = 1'b1;
    wait_writes("stall_writes", base_w + 2, 80);

    // 4: credit limit with 12 addresses and responses withheld
    @(posedge clk); #2;
    resp_budget = 0;
    base_a = acc_count;
    base_w = wr_count;
    for (int i = 0; i < 12; i++) push_addr(18'h1000 + 18'(4 * i));
    cycles(40);
    chk("credit_accepts", 32'(acc_count - base_a), MAXO);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("credit_fifo_re", bus.fifo_re, 0);
    end
    @(posedge clk); #2;
    resp_budget = 1;
    cycles(15);
    chk("credit_one_more", 32'(acc_count - base_a), MAXO + 1);
    resp_budget = -1;
    wait_writes("credit_drain", base_w + 12, 300);

    // 5: accept/response overlap at outstanding 3 and slot wrap over 17 writes
    cycles(5);
    do_reset();
    wr_log.delete();
    base_w = wr_count;
    resp_delay = 5;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_addr(18'h2000 + 18'(4 * i));
    k = 0;
    while (!chk_out_flag && k < 60) begin
      @(posedge clk); #2;
      k++;
    end
    @(negedge clk); #1;
    chk("overlap_outstanding_3", dut.outstanding_reg, 3);
    wait_writes("wrap_writes", base_w + 17, 400);
    chk("wrap_slot15", wr_log[15].slot, 15);
    chk("wrap_slot0", wr_log[16].slot, 0);
    chk("wrap_data", wr_log[16].data, data_of(18'h2000 + 18'(4 * 16)));

    // 6a: spurious response with nothing in flight
    cycles(5);
    inject = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("spurious_no_we", bus.cache_we, 0);
    end
    chk("spurious_err", err, 1);
    cycles(3);
    chk("err_sticky", err, 1);

    // 6b: reset while in ISSUE with 4 reads in flight
    resp_budget = 0;
    base_a = acc_count;
    for (int i = 0; i < 5; i++) push_addr(18'h3000 + 18'(4 * i));
    k = 0;
    while ((acc_count - base_a) < 4 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    bus.mem_req_ready = 1'b0;
    chk("pre_reset_accepts", 32'(acc_count - base_a), 4);
    wait_valid("pre_reset_issue", 20);
    chk("pre_reset_outstanding", dut.outstanding_reg, 4);
    @(posedge clk); #2;
    reset = 1'b1;
    clear_model();
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("rst_state_idle", dut.state_reg, 0);
    chk("rst_outstanding", dut.outstanding_reg, 0);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_fifo_re", bus.fifo_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
